// File: rtl/sram_mem_ctrl_if.sv
// Core-side data-memory request bus of the SRAM bridge.
// The pipeline MEM stage is the master; the controller is the slave.
interface sram_mem_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, ready);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, ready);
endinterface

// File: rtl/sram_mem_ctrl.sv
// Bridges 32-bit word requests onto a 16-bit asynchronous SRAM: each word is
// moved as a low then a high halfword, each held on the pins for WAIT_CYCLES.
module sram_mem_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_ctrl_if.slave     bus,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               isWrite_q, isWrite_d;
  logic [SRAM_AW-2:0] waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sramAddr_q, sramAddr_d;

  logic               busReady;
  logic               weN;
  logic               dqOe;
  logic [15:0]        dqOut;
  logic [31:0]        byteOffset;
  logic [SRAM_AW-2:0] wordIdx;
  logic               lastCycle;
  logic               unusedOffsetBits;

  // Out-of-range addresses simply wrap: the discarded offset bits are dropped.
  assign byteOffset       = bus.addr - 32'(BASE_ADDR);
  assign wordIdx          = byteOffset[SRAM_AW:2];
  assign unusedOffsetBits = ^{byteOffset[31:SRAM_AW+1], byteOffset[1:0]};
  assign lastCycle        = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    isWrite_d  = isWrite_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    sramAddr_d = sramAddr_q;
    busReady   = 1'b0;
    weN        = 1'b1;
    dqOe       = 1'b0;
    dqOut      = wdata_q[15:0];

    case (state_q)
      IDLE: begin
        busReady = !(bus.rd_en || bus.wr_en);
        if (bus.rd_en || bus.wr_en) begin
          isWrite_d  = bus.wr_en;
          waddr_d    = wordIdx;
          wdata_d    = bus.wdata;
          cnt_d      = '0;
          sramAddr_d = {wordIdx, 1'b0};
          state_d    = LO;
        end
      end
      LO: begin
        weN   = !isWrite_q;
        dqOe  = isWrite_q;
        dqOut = wdata_q[15:0];
        cnt_d = cnt_q + CW'(1);
        if (lastCycle) begin
          cnt_d      = '0;
          sramAddr_d = {waddr_q, 1'b1};
          state_d    = HI;
          if (!isWrite_q) begin
            rdata_d[15:0] = SRAM_DQ;
          end
        end
      end
      HI: begin
        weN   = !isWrite_q;
        dqOe  = isWrite_q;
        dqOut = wdata_q[31:16];
        cnt_d = cnt_q + CW'(1);
        if (lastCycle) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!isWrite_q) begin
            rdata_d[31:16] = SRAM_DQ;
          end
        end
      end
      DONE: begin
        // A request still held here is deliberately not restarted until IDLE.
        busReady = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      isWrite_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      sramAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isWrite_q  <= isWrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      sramAddr_q <= sramAddr_d;
    end
  end

  // Strobe and bus enable decode straight from state so reset releases them at once.
  assign SRAM_DQ   = dqOe ? dqOut : 16'bz;
  assign SRAM_WE_N = weN;
  assign SRAM_ADDR = sramAddr_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign bus.rdata = rdata_q;
  assign bus.ready = busReady;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: a board SRAM model plus a word-level reference memory
// checked against directed and random word accesses.
module tb_sram_mem_ctrl;

  localparam int WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;
  int doneCycle  = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Default-parameter DUT with a behavioural SRAM on its pins.
  sram_mem_ctrl_if memBus ();
  wire  [15:0] dqBus;
  logic [17:0] addrBus;
  logic        weN, ubN, lbN, ceN, oeN;

  sram_mem_ctrl dut (
    .clk(clk), .rst(rst), .bus(memBus),
    .SRAM_DQ(dqBus), .SRAM_ADDR(addrBus),
    .SRAM_UB_N(ubN), .SRAM_LB_N(lbN), .SRAM_CE_N(ceN), .SRAM_OE_N(oeN),
    .SRAM_WE_N(weN)
  );

  // Single-wait-cycle build; its bus only ever sees the pull-ups.
  sram_mem_ctrl_if memBus1 ();
  wire  [15:0] dqBus1;
  logic [17:0] addrBus1;
  logic        weN1, ubN1, lbN1, ceN1, oeN1;

  sram_mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(memBus1),
    .SRAM_DQ(dqBus1), .SRAM_ADDR(addrBus1),
    .SRAM_UB_N(ubN1), .SRAM_LB_N(lbN1), .SRAM_CE_N(ceN1), .SRAM_OE_N(oeN1),
    .SRAM_WE_N(weN1)
  );

  // An undriven bus reads as all ones, which makes high-Z observable.
  for (genvar g = 0; g < 16; g++) begin : gPull
    pullup (dqBus[g]);
    pullup (dqBus1[g]);
  end

  logic [15:0] sramMem [0:255];
  logic        sramOe = 1'b0;

  assign dqBus = (sramOe && weN) ? sramMem[addrBus[7:0]] : 16'bz;

  always @(negedge clk) begin
    if (!weN) sramMem[addrBus[7:0]] <= dqBus;
  end

  logic [31:0] refWord [int];
  logic [31:0] expRdata = 32'h0;

  function automatic logic [31:0] refRead(input int idx);
    return refWord.exists(idx) ? refWord[idx] : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // op: 0 = read, 1 = write, 2 = both requested (must behave as a write).
  task automatic applyStimulus(input int op, input logic [31:0] a,
                               input logic [31:0] d, input bit hold);
    bit          isWr;
    int          idx;
    logic [31:0] offs;
    logic [17:0] loAddr, hiAddr;
    isWr   = (op != 0);
    offs   = (a - 32'd1024) >> 2;
    idx    = int'(offs % 32'd131072);
    loAddr = 18'(idx * 2);
    hiAddr = 18'(idx * 2 + 1);
    memBus.wr_en = (op != 0);
    memBus.rd_en = (op != 1);
    memBus.addr  = a;
    memBus.wdata = d;
    sramOe = !isWr;
    #1;
    checkOutput("idleReady", {31'b0, memBus.ready}, 32'd0);
    checkOutput("rdataHold", memBus.rdata, expRdata);
    for (int c = 1; c <= 2 * WAIT; c++) begin
      step();
      memBus.addr  = $urandom;
      memBus.wdata = $urandom;
      #1;
      checkOutput("phaseAddr", {14'b0, addrBus}, (c > WAIT) ? {14'b0, hiAddr} : {14'b0, loAddr});
      checkOutput("phaseReady", {31'b0, memBus.ready}, 32'd0);
      checkOutput("phaseWeN", {31'b0, weN}, isWr ? 32'd0 : 32'd1);
      if (isWr)
        checkOutput("phaseDq", {16'b0, dqBus}, (c > WAIT) ? {16'b0, d[31:16]} : {16'b0, d[15:0]});
    end
    step();
    sramOe = 1'b0;
    #1;
    if (isWr) refWord[idx] = d;
    else      expRdata = refRead(idx);
    doneCycle = cycleCount;
    checkOutput("doneReady", {31'b0, memBus.ready}, 32'd1);
    checkOutput("doneWeN", {31'b0, weN}, 32'd1);
    checkOutput("doneDqZ", {16'b0, dqBus}, 32'h0000FFFF);
    checkOutput("doneAddr", {14'b0, addrBus}, {14'b0, hiAddr});
    checkOutput("doneRdata", memBus.rdata, expRdata);
    if (!hold) begin
      memBus.wr_en = 1'b0;
      memBus.rd_en = 1'b0;
    end
  endtask

  task automatic runTxn(input int op, input logic [31:0] a, input logic [31:0] d);
    applyStimulus(op, a, d, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          firstDone;
    logic [31:0] tmp;
    for (int i = 0; i < 256; i++) sramMem[i] = 16'h0;
    memBus.wr_en  = 1'b0; memBus.rd_en  = 1'b0; memBus.addr  = 32'h0; memBus.wdata  = 32'h0;
    memBus1.wr_en = 1'b0; memBus1.rd_en = 1'b0; memBus1.addr = 32'h0; memBus1.wdata = 32'h0;
    rst = 1'b1;
    step();
    step();
    #1;
    checkOutput("rstReady", {31'b0, memBus.ready}, 32'd1);
    checkOutput("rstRdata", memBus.rdata, 32'h0);
    checkOutput("rstWeN", {31'b0, weN}, 32'd1);
    checkOutput("rstAddr", {14'b0, addrBus}, 32'h0);
    checkOutput("rstDqZ", {16'b0, dqBus}, 32'h0000FFFF);
    checkOutput("tiedLow", {28'b0, ubN, lbN, ceN, oeN}, 32'h0);
    checkOutput("tiedLow1", {28'b0, ubN1, lbN1, ceN1, oeN1}, 32'h0);
    checkOutput("rstWeN1", {31'b0, weN1}, 32'd1);
    rst = 1'b0;
    step();

    $display("[TB] directed accesses");
    runTxn(1, 32'd1024, 32'h12345678);
    runTxn(0, 32'd1024, 32'h0);
    runTxn(0, 32'd1028, 32'h0);
    runTxn(2, 32'd1032, 32'hDEADBEEF);
    runTxn(0, 32'd1032, 32'h0);
    runTxn(0, 32'd1024 + 32'd524288 + 32'd8, 32'h0);

    $display("[TB] back-to-back reads");
    applyStimulus(0, 32'd1024, 32'h0, 1'b1);
    firstDone = doneCycle;
    memBus.addr = 32'd1028;
    step();
    applyStimulus(0, 32'd1028, 32'h0, 1'b0);
    checkOutput("b2bSpacing", 32'(doneCycle - firstDone), 32'd6);
    step();

    $display("[TB] reset during write");
    runTxn(1, 32'd1040, 32'hAAAA5555);
    memBus.wr_en = 1'b1;
    memBus.addr  = 32'd1040;
    memBus.wdata = 32'h12345678;
    step();
    step();
    step();
    checkOutput("preRstWeN", {31'b0, weN}, 32'd0);
    rst = 1'b1;
    memBus.wr_en = 1'b0;
    #1;
    checkOutput("abortWeN", {31'b0, weN}, 32'd1);
    checkOutput("abortDqZ", {16'b0, dqBus}, 32'h0000FFFF);
    checkOutput("abortReady", {31'b0, memBus.ready}, 32'd1);
    tmp = refRead(4);
    refWord[4] = {tmp[31:16], 16'h5678};
    expRdata = 32'h0;
    step();
    rst = 1'b0;
    step();
    runTxn(0, 32'd1040, 32'h0);

    $display("[TB] random accesses");
    for (int n = 0; n < 40; n++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = 32'd1024 + 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom_range(0, 3));
      runTxn(op, a, $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("[TB] single wait-cycle build");
    memBus1.rd_en = 1'b1;
    memBus1.addr  = 32'd1024;
    #1;
    checkOutput("w1Cycle0Ready", {31'b0, memBus1.ready}, 32'd0);
    step();
    checkOutput("w1LoAddr", {14'b0, addrBus1}, 32'd0);
    memBus1.addr = 32'd2000;
    #1;
    checkOutput("w1LoReady", {31'b0, memBus1.ready}, 32'd0);
    step();
    memBus1.addr = 32'd1100;
    #1;
    checkOutput("w1HiAddr", {14'b0, addrBus1}, 32'd1);
    checkOutput("w1HiReady", {31'b0, memBus1.ready}, 32'd0);
    step();
    checkOutput("w1DoneReady", {31'b0, memBus1.ready}, 32'd1);
    checkOutput("w1DoneAddr", {14'b0, addrBus1}, 32'd1);
    checkOutput("w1Rdata", memBus1.rdata, 32'hFFFFFFFF);
    memBus1.rd_en = 1'b0;
    step();
    #1;
    checkOutput("w1IdleReady", {31'b0, memBus1.ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
